// File: rtl/alu_rsv_station.sv
// ALU reservation station: holds dispatched ALU ops until both operands are
// known, wakes them from CDB broadcasts, and issues the oldest ready entry
// through a registered issue port.

package core_pkg;
  localparam int XLEN       = 32;
  localparam int LOG2_PREGS = 6;
endpackage

module alu_rsv_station #(
  parameter int XLEN   = core_pkg::XLEN,
  parameter int PHYS_W = core_pkg::LOG2_PREGS,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  // Dispatch handshake: an op is accepted on a rising edge where
  // disp_valid && disp_ready && !flush. disp_ready comes only from registered
  // occupancy, so it never depends on disp_valid or on a same-cycle issue.
  input  logic                         disp_valid,
  output logic                         disp_ready,
  input  logic [7:0]                   disp_op,
  input  logic [PHYS_W-1:0]            disp_dst_tag,
  input  logic [5:0]                   disp_rob_tag,
  input  logic [PHYS_W-1:0]            disp_src1_tag,
  input  logic                         disp_src1_rdy,
  input  logic [XLEN-1:0]              disp_src1_val,
  input  logic [PHYS_W-1:0]            disp_src2_tag,
  input  logic                         disp_src2_rdy,
  input  logic [XLEN-1:0]              disp_src2_val,
  input  logic                         cdb_valid,
  input  logic [PHYS_W-1:0]            cdb_tag,
  input  logic [XLEN-1:0]              cdb_value,
  output logic                         issue_valid,
  output logic [7:0]                   issue_op,
  output logic [PHYS_W-1:0]            issue_dst_tag,
  output logic [XLEN-1:0]              issue_src1_val,
  output logic [XLEN-1:0]              issue_src2_val,
  output logic [5:0]                   issue_rob_tag,
  output logic [$clog2(DEPTH):0]       occupancy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int SEQ_W = IDX_W + 1;
  localparam int OCC_W = IDX_W + 1;

  typedef struct packed {
    logic              valid;
    logic [7:0]        op;
    logic [PHYS_W-1:0] dst_tag;
    logic [5:0]        rob_tag;
    logic [PHYS_W-1:0] src1_tag;
    logic              src1_rdy;
    logic [XLEN-1:0]   src1_val;
    logic [PHYS_W-1:0] src2_tag;
    logic              src2_rdy;
    logic [XLEN-1:0]   src2_val;
    logic [SEQ_W-1:0]  seq;
  } entry_t;

  entry_t            ent_q [DEPTH];
  logic [SEQ_W-1:0]  seq_q;

  logic [OCC_W-1:0]  occ_c;
  logic [IDX_W-1:0]  free_idx;
  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx;
  logic [SEQ_W-1:0]  sel_seq;
  logic              disp_fire;
  entry_t            new_ent;

  // a is older than b when (a - b) is negative modulo 2^SEQ_W; at most DEPTH
  // entries are live, so the distance always fits in half the counter range.
  function automatic logic seq_older(input logic [SEQ_W-1:0] a,
                                     input logic [SEQ_W-1:0] b);
    logic [SEQ_W-1:0] d;
    d = a - b;
    return d[SEQ_W-1];
  endfunction

  // Count valid entries from registered state only.
  always_comb begin
    occ_c = '0;
    for (int i = 0; i < DEPTH; i++) occ_c = occ_c + OCC_W'(ent_q[i].valid);
  end

  assign occupancy  = occ_c;
  assign disp_ready = (occ_c < OCC_W'(DEPTH));
  assign disp_fire  = disp_valid && disp_ready && !flush;

  // Lowest-index free entry receives the next dispatch.
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!ent_q[i].valid) free_idx = IDX_W'(i);
    end
  end

  // Oldest eligible entry (valid with both registered ready bits set).
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_seq   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].valid && ent_q[i].src1_rdy && ent_q[i].src2_rdy) begin
        if (!sel_found || seq_older(ent_q[i].seq, sel_seq)) begin
          sel_found = 1'b1;
          sel_idx   = IDX_W'(i);
          sel_seq   = ent_q[i].seq;
        end
      end
    end
  end

  // Build the incoming entry, capturing a same-cycle CDB value for any
  // source that arrives not ready.
  always_comb begin
    new_ent          = '0;
    new_ent.valid    = 1'b1;
    new_ent.op       = disp_op;
    new_ent.dst_tag  = disp_dst_tag;
    new_ent.rob_tag  = disp_rob_tag;
    new_ent.src1_tag = disp_src1_tag;
    new_ent.src2_tag = disp_src2_tag;
    new_ent.seq      = seq_q;
    new_ent.src1_rdy = disp_src1_rdy;
    new_ent.src1_val = disp_src1_val;
    new_ent.src2_rdy = disp_src2_rdy;
    new_ent.src2_val = disp_src2_val;
    if (!disp_src1_rdy && cdb_valid && (cdb_tag == disp_src1_tag)) begin
      new_ent.src1_rdy = 1'b1;
      new_ent.src1_val = cdb_value;
    end
    if (!disp_src2_rdy && cdb_valid && (cdb_tag == disp_src2_tag)) begin
      new_ent.src2_rdy = 1'b1;
      new_ent.src2_val = cdb_value;
    end
  end

  // Entry storage, wakeup, issue register and allocation counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      seq_q          <= '0;
      issue_valid    <= 1'b0;
      issue_op       <= '0;
      issue_dst_tag  <= '0;
      issue_src1_val <= '0;
      issue_src2_val <= '0;
      issue_rob_tag  <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i].valid <= 1'b0;
      issue_valid <= 1'b0;
    end else begin
      if (cdb_valid) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (ent_q[i].valid && !ent_q[i].src1_rdy && (ent_q[i].src1_tag == cdb_tag)) begin
            ent_q[i].src1_rdy <= 1'b1;
            ent_q[i].src1_val <= cdb_value;
          end
          if (ent_q[i].valid && !ent_q[i].src2_rdy && (ent_q[i].src2_tag == cdb_tag)) begin
            ent_q[i].src2_rdy <= 1'b1;
            ent_q[i].src2_val <= cdb_value;
          end
        end
      end
      issue_valid <= sel_found;
      if (sel_found) begin
        issue_op       <= ent_q[sel_idx].op;
        issue_dst_tag  <= ent_q[sel_idx].dst_tag;
        issue_src1_val <= ent_q[sel_idx].src1_val;
        issue_src2_val <= ent_q[sel_idx].src2_val;
        issue_rob_tag  <= ent_q[sel_idx].rob_tag;
        ent_q[sel_idx].valid <= 1'b0;
      end
      // The free slot is never the issuing slot, so both writes coexist.
      if (disp_fire) begin
        ent_q[free_idx] <= new_ent;
        seq_q           <= seq_q + 1'b1;
      end
    end
  end

endmodule

// File: doc/alu_rsv_station.md
ALU_RSV_STATION -- requirements
Module: alu_rsv_station

Interface
REQ-001 The module SHALL have parameter XLEN, default core_pkg::XLEN (32), meaning the operand width.
REQ-002 The module SHALL have parameter PHYS_W, default core_pkg::LOG2_PREGS, meaning the physical tag width.
REQ-003 The module SHALL have parameter DEPTH, default 4, meaning the number of entries (power of 2, 2..8).
REQ-004 The module SHALL use one clock and a synchronous, active-high reset.
REQ-005 The module SHALL have these ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- flush  in  1  discard all entries
- disp_valid  in  1  dispatch request
- disp_ready  out  1  entry free
- disp_op  in  8  opcode/function
- disp_dst_tag  in  PHYS_W  destination tag
- disp_rob_tag  in  6  ROB index
- disp_src1_tag  in  PHYS_W  source-1 tag
- disp_src1_rdy  in  1  source-1 value valid
- disp_src1_val  in  XLEN  source-1 value
- disp_src2_tag  in  PHYS_W  source-2 tag
- disp_src2_rdy  in  1  source-2 value valid
- disp_src2_val  in  XLEN  source-2 value or immediate
- cdb_valid  in  1  CDB broadcast
- cdb_tag  in  PHYS_W  broadcast tag
- cdb_value  in  XLEN  broadcast value
- issue_valid  out  1  issue to ALU
- issue_op  out  8  opcode/function
- issue_dst_tag  out  PHYS_W  destination tag
- issue_src1_val  out  XLEN  operand 1
- issue_src2_val  out  XLEN  operand 2
- issue_rob_tag  out  6  ROB index
- occupancy  out  clog2(DEPTH)+1  valid-entry count

Function
REQ-006 Each entry SHALL hold: valid, op, dst_tag, rob_tag, per source {tag, rdy, val}, and an allocation sequence number.
REQ-007 disp_ready SHALL equal (occupancy < DEPTH) and be derived only from registered state; an entry freed in the same cycle does not raise it.
REQ-008 Dispatch SHALL occur on a clock edge where disp_valid && disp_ready && !flush, writing the lowest-index free entry.
REQ-009 Dispatch bypass: if cdb_valid and cdb_tag equals a not-ready disp_srcN_tag in the dispatch cycle, that source SHALL be written rdy=1 with cdb_value.
REQ-010 Wakeup: on each edge with cdb_valid, every valid entry with a not-ready source whose tag equals cdb_tag SHALL set rdy=1 and capture cdb_value; both sources of one entry can wake on the same broadcast.
REQ-011 An entry SHALL be issue-eligible in a cycle when it is valid and both registered rdy bits are 1.
REQ-012 Select: among eligible entries, the oldest by allocation sequence SHALL be chosen; at most one issue per cycle.
REQ-013 Issue outputs SHALL be registered: the selected entry's fields appear on issue_* with issue_valid=1 in the cycle after selection; the entry is invalidated on that same edge.
REQ-014 issue_valid SHALL be 0 in any cycle following a cycle with no eligible entry; issue_* data is don't-care then but holds last value.
REQ-015 Minimum latency SHALL be: dispatch handshake in cycle C with both sources ready -> issue_valid in cycle C+2; CDB wakeup in cycle W -> issue_valid earliest W+2.
REQ-016 Dispatch and issue on the same edge SHALL both take effect; occupancy = old + 1 - 1.
REQ-017 Sequence numbers SHALL be compared wrap-safely (width >= clog2(DEPTH)+1, modular compare) so ordering survives counter wrap-around.
REQ-018 flush SHALL, on its edge, invalidate all entries, force issue_valid=0 next cycle, and block any same-cycle dispatch; CDB updates in that cycle are ignored.
REQ-019 The module SHALL issue only from entries that are valid; CDB matches on invalid entries SHALL have no effect.

Reset
REQ-020 On an edge with reset=1, all entries SHALL become invalid, the sequence counter SHALL be 0, and occupancy=0, disp_ready=1, issue_valid=0, all issue_* data=0.
REQ-021 Reset SHALL take priority over flush, dispatch, wakeup, and issue; reset mid-operation drops all pending entries without issuing them.

Verification
REQ-022 ADD (op=8'h20) dispatched in cycle 1 with src1=5, src2=7, both ready -> issue_valid=1 in cycle 3 carrying 5, 7, dst/rob tags; occupancy back to 0 in cycle 3.
REQ-023 Dispatch src1_tag=12 not ready; CDB tag=12 value=0x99 in cycle 4 -> issue_valid cycle 6 with issue_src1_val=0x99; a CDB with tag=13 causes no issue.
REQ-024 Fill 4 entries, none ready -> disp_ready=0 while full; wake entries in reverse allocation order in one cycle via a shared tag -> issue order equals allocation order, one per cycle.
REQ-025 Dispatch with disp_src2_tag==cdb_tag and cdb_valid in the same cycle -> src2 captured as cdb_value, issue at C+2.
REQ-026 Flush with 3 valid entries, plus disp_valid in the same cycle -> occupancy=0, no issue_valid next cycle, dispatched op dropped.
REQ-027 Assert reset for one cycle while 2 entries ready -> outputs match REQ-020, no issue follows; sustained dispatch/issue beyond 2^seq_width allocations preserves oldest-first order.
